// File: rtl/pmp_csr_file_if.sv
// Shared RISC-V types for the PMP CSR block, followed by the CSR request/response
// bus between the CSR pipeline (master) and the PMP CSR file (slave).

package riscv;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_addr_mode_t;

  // One pmpcfg byte: L, reserved[1:0], A[1:0], X, W, R (MSB first).
  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    logic           x;
    logic           w;
    logic           r;
  } pmpcfg_t;

endpackage

interface pmp_csr_file_if;
  logic                csr_req_i;
  logic [11:0]         csr_addr_i;
  logic [1:0]          csr_op_i;
  logic [31:0]         csr_wdata_i;
  riscv::priv_lvl_t    priv_lvl_i;
  logic                csr_rvalid_o;
  logic [31:0]         csr_rdata_o;
  logic                csr_error_o;

  modport master (
    output csr_req_i, csr_addr_i, csr_op_i, csr_wdata_i, priv_lvl_i,
    input  csr_rvalid_o, csr_rdata_o, csr_error_o
  );

  modport slave (
    input  csr_req_i, csr_addr_i, csr_op_i, csr_wdata_i, priv_lvl_i,
    output csr_rvalid_o, csr_rdata_o, csr_error_o
  );
endinterface

// File: rtl/pmp_csr_file.sv
// Machine-mode storage for pmpcfg0 and pmpaddr0..3 of a 4-entry PMP.
// Executes read/write/set/clear with WARL legalisation and lock rules, drives the
// checker's configuration directly from registers, and pulses pmp_update_o
// whenever the stored configuration changes.

module pmp_csr_file (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  pmp_csr_file_if.slave          csr,
  output riscv::pmpcfg_t [3:0]   conf_o,
  output logic [3:0][31:0]       conf_addr_o,
  output logic                   pmp_update_o
);

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  logic                 is_cfg;
  logic                 is_addr;
  logic                 access_err;
  logic                 do_write;
  logic [1:0]           addr_idx;
  logic [1:0]           next_idx;
  logic                 addr_locked;
  logic [31:0]          old_val;
  logic [31:0]          new_val;
  riscv::pmpcfg_t [3:0] cfg_d;
  logic [3:0][31:0]     addr_d;

  // Reserved bits never store; W without R is not a legal permission.
  function automatic riscv::pmpcfg_t legalize_cfg(input logic [7:0] raw);
    riscv::pmpcfg_t c;
    c          = raw;
    c.reserved = 2'b00;
    if (!c.r) c.w = 1'b0;
    return c;
  endfunction

  // Decode the request, check privilege/address and build the candidate value.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    new_val    = '0;
    is_cfg     = (csr.csr_addr_i == CSR_PMPCFG0);
    is_addr    = (csr.csr_addr_i[11:2] == CSR_PMPADDR0[11:2]);
    addr_idx   = csr.csr_addr_i[1:0];
    access_err = (csr.priv_lvl_i != riscv::PRIV_LVL_M) || !(is_cfg || is_addr);
    old_val    = is_cfg ? conf_o : conf_addr_o[addr_idx];
    unique case (riscv::csr_op_t'(csr.csr_op_i))
      riscv::CSR_READ:  new_val = old_val;
      riscv::CSR_WRITE: new_val = csr.csr_wdata_i;
      riscv::CSR_SET:   new_val = old_val | csr.csr_wdata_i;
      riscv::CSR_CLEAR: new_val = old_val & ~csr.csr_wdata_i;
      default:          new_val = old_val;
    endcase
    do_write = csr.csr_req_i && !access_err &&
               (riscv::csr_op_t'(csr.csr_op_i) != riscv::CSR_READ);
  end

  // Next register state: per-byte lock on pmpcfg0, entry/TOR lock on pmpaddr.
  always_comb begin
    cfg_d    = conf_o;
    addr_d   = conf_addr_o;
    next_idx = addr_idx + 2'd1;
    // Entry i+1 in TOR mode uses pmpaddr i as its base, so its lock protects it too.
    addr_locked = conf_o[addr_idx].locked ||
                  ((addr_idx != 2'd3) && conf_o[next_idx].locked &&
                   (conf_o[next_idx].addr_mode == riscv::PMP_TOR));
    if (do_write && is_cfg) begin
      for (int i = 0; i < 4; i++) begin
        if (!conf_o[i].locked) cfg_d[i] = legalize_cfg(new_val[8*i +: 8]);
      end
    end
    if (do_write && is_addr && !addr_locked) addr_d[addr_idx] = new_val;
  end

  // Registered state, response and change pulse; synchronous reset wins over a request.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      conf_o           <= '0;
      conf_addr_o      <= '0;
      pmp_update_o     <= 1'b0;
      csr.csr_rvalid_o <= 1'b0;
      csr.csr_rdata_o  <= '0;
      csr.csr_error_o  <= 1'b0;
    end else begin
      conf_o           <= cfg_d;
      conf_addr_o      <= addr_d;
      pmp_update_o     <= (cfg_d != conf_o) || (addr_d != conf_addr_o);
      csr.csr_rvalid_o <= csr.csr_req_i;
      if (csr.csr_req_i) begin
        csr.csr_error_o <= access_err;
        csr.csr_rdata_o <= access_err ? 32'h0 : old_val;
      end
    end
  end

endmodule

// File: tb/tb_pmp_csr_file.sv
// Self-checking bench for pmp_csr_file: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// byte/word-level reference model of the PMP CSR rules.

module tb_pmp_csr_file;

  logic                 clk;
  logic                 rst_n;
  riscv::pmpcfg_t [3:0] conf_o;
  logic [3:0][31:0]     conf_addr_o;
  logic                 pmp_update_o;

  pmp_csr_file_if bus ();

  pmp_csr_file dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .csr          (bus.slave),
    .conf_o       (conf_o),
    .conf_addr_o  (conf_addr_o),
    .pmp_update_o (pmp_update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_cfg  [4];
  logic [31:0] m_addr [4];
  logic        e_rvalid, e_err, e_upd;
  logic [31:0] e_rdata;
  bit          armed = 0;

  function automatic logic [7:0] legal_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b & 8'h9F;
    if (r[0] == 1'b0) r[1] = 1'b0;
    return r;
  endfunction

  function automatic bit addr_is_locked(input int k);
    if (m_cfg[k][7]) return 1;
    if (k < 3 && m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'd1) return 1;
    return 0;
  endfunction

  // Model step at each rising edge, then compare the DUT just after the edge.
  initial begin
    logic [7:0]  prev_cfg  [4];
    logic [31:0] prev_addr [4];
    logic [31:0] old_v, new_v, a_w;
    logic        s_rst, s_req;
    logic [11:0] s_a;
    logic [1:0]  s_op;
    logic [31:0] s_wd;
    riscv::priv_lvl_t s_priv;
    bit          in_reset;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_req = bus.csr_req_i; s_a = bus.csr_addr_i;
      s_op = bus.csr_op_i; s_wd = bus.csr_wdata_i; s_priv = bus.priv_lvl_i;
      in_reset = !s_rst;
      if (!s_rst) begin
        for (int i = 0; i < 4; i++) begin m_cfg[i] = 8'h0; m_addr[i] = 32'h0; end
        e_rvalid = 0; e_err = 0; e_upd = 0; e_rdata = 0;
        armed = 1;
      end else if (armed) begin
        for (int i = 0; i < 4; i++) begin prev_cfg[i] = m_cfg[i]; prev_addr[i] = m_addr[i]; end
        e_rvalid = s_req;
        if (s_req) begin
          if (s_priv != riscv::PRIV_LVL_M ||
              !(s_a == 12'h3A0 || (s_a >= 12'h3B0 && s_a <= 12'h3B3))) begin
            e_err = 1; e_rdata = 0;
          end else begin
            e_err = 0;
            old_v = (s_a == 12'h3A0) ? {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]}
                                     : m_addr[s_a - 12'h3B0];
            e_rdata = old_v;
            case (s_op)
              2'd1:    new_v = s_wd;
              2'd2:    new_v = old_v | s_wd;
              2'd3:    new_v = old_v & ~s_wd;
              default: new_v = old_v;
            endcase
            if (s_op != 2'd0) begin
              if (s_a == 12'h3A0) begin
                for (int i = 0; i < 4; i++)
                  if (!prev_cfg[i][7]) m_cfg[i] = legal_byte(new_v[8*i +: 8]);
              end else if (!addr_is_locked(int'(s_a - 12'h3B0))) begin
                m_addr[s_a - 12'h3B0] = new_v;
              end
            end
          end
        end
        e_upd = 0;
        for (int i = 0; i < 4; i++)
          if (m_cfg[i] != prev_cfg[i] || m_addr[i] != prev_addr[i]) e_upd = 1;
      end
      #1;
      if (armed) begin
        check("rvalid", {31'h0, bus.csr_rvalid_o}, {31'h0, e_rvalid});
        check("pmp_update", {31'h0, pmp_update_o}, {31'h0, e_upd});
        for (int i = 0; i < 4; i++) begin
          check($sformatf("conf[%0d]", i), {24'h0, conf_o[i]}, {24'h0, m_cfg[i]});
          a_w = conf_addr_o[i];
          check($sformatf("conf_addr[%0d]", i), a_w, m_addr[i]);
        end
        if (e_rvalid || in_reset) begin
          check("rdata", bus.csr_rdata_o, e_rdata);
          check("error", {31'h0, bus.csr_error_o}, {31'h0, e_err});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input riscv::priv_lvl_t p);
    bus.csr_req_i = 1'b1; bus.csr_addr_i = a; bus.csr_op_i = op;
    bus.csr_wdata_i = wd; bus.priv_lvl_i = p;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.csr_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.csr_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam riscv::priv_lvl_t M = riscv::PRIV_LVL_M;
  localparam riscv::priv_lvl_t S = riscv::PRIV_LVL_S;

  logic [31:0] w;

  initial begin
    rst_n = 1'b0;
    bus.csr_req_i = 1'b0; bus.csr_addr_i = '0; bus.csr_op_i = '0;
    bus.csr_wdata_i = '0; bus.priv_lvl_i = M;
    @(negedge clk);
    do_reset();
    check("reset conf", conf_o, 32'h0);
    w = conf_addr_o[1];
    check("reset addr1", w, 32'h0);
    check("reset update", {31'h0, pmp_update_o}, 32'h0);

    // Address then TOR/XWR configuration for entry 1.
    drive(12'h3B1, 2'd1, 32'h0000_1000, M);
    w = conf_addr_o[1];
    check("addr1 written", w, 32'h1000);
    check("addr1 pulse", {31'h0, pmp_update_o}, 32'h1);
    drive(12'h3A0, 2'd1, 32'h0000_0F00, M);
    check("cfg1 TOR XWR", {24'h0, conf_o[1]}, 32'h0F);
    check("cfg1 pulse", {31'h0, pmp_update_o}, 32'h1);

    // Lock entry 0, then try to clear it and overwrite pmpaddr0.
    drive(12'h3A0, 2'd1, 32'h0000_008F, M);
    check("cfg lock0", conf_o, 32'h0000_008F);
    drive(12'h3A0, 2'd1, 32'h0000_0000, M);
    check("cfg locked byte kept", conf_o, 32'h0000_008F);
    check("cfg no-change no pulse", {31'h0, pmp_update_o}, 32'h0);
    drive(12'h3B0, 2'd1, 32'hFFFF_FFFF, M);
    w = conf_addr_o[0];
    check("addr0 locked", w, 32'h0);
    check("addr0 locked no error", {31'h0, bus.csr_error_o}, 32'h0);
    check("addr0 locked no pulse", {31'h0, pmp_update_o}, 32'h0);
    idle();

    // Entry 2 locked TOR protects pmpaddr1 but not pmpaddr3.
    do_reset();
    drive(12'h3A0, 2'd1, 32'h0089_0000, M);
    drive(12'h3B1, 2'd1, 32'h0000_1234, M);
    w = conf_addr_o[1];
    check("tor lock addr1", w, 32'h0);
    check("tor lock no error", {31'h0, bus.csr_error_o}, 32'h0);
    check("tor lock no pulse", {31'h0, pmp_update_o}, 32'h0);
    drive(12'h3B3, 2'd1, 32'h0000_ABCD, M);
    w = conf_addr_o[3];
    check("addr3 free", w, 32'hABCD);

    // WARL legalisation and illegal accesses.
    do_reset();
    drive(12'h3B0, 2'd1, 32'h0000_0055, M);
    drive(12'h3A0, 2'd1, 32'h0000_0062, M);
    check("warl byte0", conf_o, 32'h0);
    check("warl no pulse", {31'h0, pmp_update_o}, 32'h0);
    drive(12'h3B0, 2'd0, 32'h0, S);
    check("S read error", {31'h0, bus.csr_error_o}, 32'h1);
    check("S read rdata", bus.csr_rdata_o, 32'h0);
    drive(12'h3A5, 2'd1, 32'h0000_0001, M);
    check("bad addr error", {31'h0, bus.csr_error_o}, 32'h1);
    check("bad addr rvalid", {31'h0, bus.csr_rvalid_o}, 32'h1);
    check("bad addr no pulse", {31'h0, pmp_update_o}, 32'h0);

    // Back-to-back set then clear on pmpaddr2.
    drive(12'h3B2, 2'd2, 32'h0000_000F, M);
    check("set pulse", {31'h0, pmp_update_o}, 32'h1);
    drive(12'h3B2, 2'd3, 32'h0000_0003, M);
    check("clear sees set", bus.csr_rdata_o, 32'h0000_000F);
    check("clear pulse", {31'h0, pmp_update_o}, 32'h1);
    w = conf_addr_o[2];
    check("addr2 final", w, 32'h0000_000C);
    idle();

    // Randomized traffic, checked every cycle by the model process.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(63) == 0) begin
        rst_n = 1'b0;
        bus.csr_req_i = 1'($urandom_range(1));
        @(negedge clk);
        rst_n = 1'b1;
      end else if ($urandom_range(7) == 0) begin
        idle();
      end else begin
        logic [11:0] a;
        logic [31:0] d;
        riscv::priv_lvl_t p;
        case ($urandom_range(9))
          0, 1, 2: a = 12'h3A0;
          3, 4, 5, 6: a = 12'h3B0 + 12'($urandom_range(3));
          7: a = 12'h3A0 + 12'($urandom_range(15));
          default: a = 12'($urandom);
        endcase
        d = $urandom;
        // Keep lock bits rarer so most writes still land.
        if ($urandom_range(3) != 0) d = d & 32'h7F7F_7F7F;
        case ($urandom_range(7))
          0: p = riscv::PRIV_LVL_U;
          1: p = riscv::PRIV_LVL_S;
          default: p = M;
        endcase
        drive(a, 2'($urandom_range(3)), d, p);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
